// File: rtl/mult_mem_ctrl.sv
// Write sequencer for the 8-word multiplier operand buffer: steers two 4-lane
// groups into the low/high buffer halves and tracks when the full set is resident.
module mult_mem_ctrl #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_wd1,
  input  logic [W-1:0]     in_wd2,
  input  logic [W-1:0]     in_wd3,
  input  logic [W-1:0]     in_wd4,
  input  logic             flush,
  output logic             mem_we,
  output logic             mem_half,
  output logic [W-1:0]     mem_wd1,
  output logic [W-1:0]     mem_wd2,
  output logic [W-1:0]     mem_wd3,
  output logic [W-1:0]     mem_wd4,
  output logic             buf_valid,
  input  logic             rd_ack,
  output logic [CNT_W-1:0] set_count,
  output logic             err_ack
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t state, state_nx;
  logic   accept;
  logic   set_done;
  logic   ack_ok;

  assign in_ready = (state != FULL) && !flush && !rst;
  assign accept   = in_valid && in_ready;
  // The high-half write lands one edge after its accept; the set is complete then.
  assign set_done = mem_we && mem_half;
  assign ack_ok   = rd_ack && buf_valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY:   if (accept) state_nx = HALF;
      HALF:    if (accept) state_nx = FULL;
      FULL:    if (ack_ok) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      mem_we    <= 1'b0;
      mem_half  <= 1'b0;
      mem_wd1   <= '0;
      mem_wd2   <= '0;
      mem_wd3   <= '0;
      mem_wd4   <= '0;
      buf_valid <= 1'b0;
      set_count <= '0;
      err_ack   <= 1'b0;
    end else if (flush) begin
      // An in-flight write still commits at this edge; only the bookkeeping is dropped.
      state     <= EMPTY;
      mem_we    <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      state  <= state_nx;
      mem_we <= accept;
      if (accept) begin
        mem_half <= (state == HALF);
        mem_wd1  <= in_wd1;
        mem_wd2  <= in_wd2;
        mem_wd3  <= in_wd3;
        mem_wd4  <= in_wd4;
      end
      if (set_done) begin
        buf_valid <= 1'b1;
        set_count <= set_count + CNT_W'(1);
      end else if (ack_ok) begin
        buf_valid <= 1'b0;
      end
      if (rd_ack && !buf_valid) err_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_mem_ctrl.sv
// Directed plus randomized bench for mult_mem_ctrl against a set-level model
// (halves resident, pending write, completed sets) kept in plain variables.
module tb_mult_mem_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, flush = 1'b0, in_valid = 1'b0, rd_ack = 1'b0;
  logic [W-1:0] in_wd1 = '0, in_wd2 = '0, in_wd3 = '0, in_wd4 = '0;

  logic         in_ready, mem_we, mem_half, buf_valid, err_ack;
  logic [W-1:0] mem_wd1, mem_wd2, mem_wd3, mem_wd4;
  logic [15:0]  set_count;

  logic         in_ready_w, mem_we_w, mem_half_w, buf_valid_w, err_ack_w;
  logic [W-1:0] mem_wd1_w, mem_wd2_w, mem_wd3_w, mem_wd4_w;
  logic [3:0]   set_count_w;

  mult_mem_ctrl #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wd1(in_wd1), .in_wd2(in_wd2), .in_wd3(in_wd3), .in_wd4(in_wd4),
    .flush(flush), .mem_we(mem_we), .mem_half(mem_half),
    .mem_wd1(mem_wd1), .mem_wd2(mem_wd2), .mem_wd3(mem_wd3), .mem_wd4(mem_wd4),
    .buf_valid(buf_valid), .rd_ack(rd_ack), .set_count(set_count), .err_ack(err_ack)
  );

  // Narrow counter copy so the wrap boundary is reachable in a short run.
  mult_mem_ctrl #(.W(W), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_wd1(in_wd1), .in_wd2(in_wd2), .in_wd3(in_wd3), .in_wd4(in_wd4),
    .flush(flush), .mem_we(mem_we_w), .mem_half(mem_half_w),
    .mem_wd1(mem_wd1_w), .mem_wd2(mem_wd2_w), .mem_wd3(mem_wd3_w), .mem_wd4(mem_wd4_w),
    .buf_valid(buf_valid_w), .rd_ack(rd_ack), .set_count(set_count_w), .err_ack(err_ack_w)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          halves = 0;      // groups accepted into the current set (0..2)
  bit          m_valid = 0;
  bit          m_we = 0;
  bit          m_half = 0;
  bit          m_err = 0;
  int unsigned m_sets = 0;
  logic [W-1:0] m_wd[4] = '{default: '0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit v, input bit a, input logic [W-1:0] base);
    bit exp_rdy, acc, done, old_valid;
    @(negedge clk);
    rst = r; flush = f; in_valid = v; rd_ack = a;
    in_wd1 = base + 1; in_wd2 = base + 2; in_wd3 = base + 3; in_wd4 = base + 4;
    #1;
    exp_rdy = (halves != 2) && !f && !r;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("in_ready_w", {31'd0, in_ready_w}, {31'd0, exp_rdy});
    @(posedge clk);
    if (r) begin
      halves = 0; m_valid = 0; m_we = 0; m_half = 0; m_err = 0; m_sets = 0;
      m_wd = '{default: '0};
    end else if (f) begin
      halves = 0; m_valid = 0; m_we = 0;
    end else begin
      acc       = v && exp_rdy;
      done      = m_we && m_half;
      old_valid = m_valid;
      if (done) begin
        m_valid = 1;
        m_sets++;
      end
      if (a && old_valid) begin
        m_valid = 0;
        halves  = 0;
      end
      if (a && !old_valid) m_err = 1;
      if (acc) begin
        m_we   = 1;
        m_half = (halves == 1);
        for (int i = 0; i < 4; i++) m_wd[i] = base + W'(i + 1);
        halves++;
      end else begin
        m_we = 0;
      end
    end
    #1;
    chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
    chk("mem_half", {31'd0, mem_half}, {31'd0, m_half});
    chk("mem_wd1", mem_wd1, m_wd[0]);
    chk("mem_wd2", mem_wd2, m_wd[1]);
    chk("mem_wd3", mem_wd3, m_wd[2]);
    chk("mem_wd4", mem_wd4, m_wd[3]);
    chk("buf_valid", {31'd0, buf_valid}, {31'd0, m_valid});
    chk("err_ack", {31'd0, err_ack}, {31'd0, m_err});
    chk("set_count", {16'd0, set_count}, m_sets % 65536);
    chk("set_count_w", {28'd0, set_count_w}, m_sets % 16);
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    // two back-to-back groups, then the set becomes valid
    step(0, 0, 1, 0, 32'h10);
    step(0, 0, 1, 0, 32'h20);
    step(0, 0, 0, 0, '0);
    // third group held off while FULL, accepted after the ack
    step(0, 0, 1, 0, 32'h30);
    step(0, 0, 1, 0, 32'h30);
    step(0, 0, 1, 1, 32'h30);
    step(0, 0, 1, 0, 32'h30);
    // flush together with ack in the pending-valid cycle: no err, count kept
    step(0, 0, 1, 0, 32'h40);
    step(0, 1, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    // accept then flush; flush blocks a concurrent valid; next goes low
    step(0, 0, 1, 0, 32'h50);
    step(0, 1, 0, 0, '0);
    step(0, 1, 1, 0, 32'h58);
    step(0, 0, 1, 0, 32'h60);
    step(0, 0, 1, 0, 32'h70);
    // ack in the FULL-before-valid cycle is an error
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, '0);
    // ack in EMPTY is an error; err stays set
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    // reset mid-set and in FULL
    step(0, 0, 1, 0, 32'h80);
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 0, 32'h90);
    step(0, 0, 1, 0, 32'hA0);
    step(1, 0, 1, 0, 32'hB0);
    step(0, 0, 1, 0, 32'hC0);
    step(1, 0, 0, 0, '0);
    // 17 complete sets: narrow counter wraps 15 -> 0 -> 1
    for (int s = 0; s < 17; s++) begin
      step(0, 0, 1, 0, $urandom);
      step(0, 0, 1, 0, $urandom);
      step(0, 0, 0, 0, '0);
      step(0, 0, 0, 1, '0);
    end
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 25), $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
